qie_channel_capture: RTL
========================

Name: qie_channel_capture

Overview:
Per-channel front-end capture stage between one QIE's digital outputs and the FPGA top-level formatter. It samples the 8-bit QIE output word on each QIE output-clock strobe after synchronising it into the system clock. It checks the capacitor-ID rotation and locks onto it. It buffers validated samples in a small FIFO with a valid/ready interface. Twelve instances are used, one per QIE channel.

Parameters:
SYNC_STAGES, 2, synchroniser depth for qie_ckout, qie_out and qie_discout; minimum 2.
FIFO_DEPTH, 4, sample buffer depth; power of 2, minimum 2.
LOCK_COUNT, 4, consecutive correct capID samples required to declare lock; minimum 2.
ERR_CNT_W, 8, width of the saturating capID error counter.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
qie_out  in  8  QIE output word: [7:6] capID, [5:0] ADC code.
qie_ckout  in  1  QIE output clock (asynchronous strobe).
qie_discout  in  1  QIE discriminator output (asynchronous).
out_adc  out  6  head-of-FIFO ADC code.
out_capid  out  2  head-of-FIFO capID.
out_disc  out  1  head-of-FIFO discriminator flag.
out_valid  out  1  FIFO not empty.
out_ready  in  1  consumer accepts the head word.
locked  out  1  FSM is in LOCKED.
capid_err_cnt  out  ERR_CNT_W  saturating count of capID errors while locked.
overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
clr_err  in  1  clears capid_err_cnt and overflow.

Behaviour:
- Synchronisation: qie_ckout, qie_out and qie_discout each pass through SYNC_STAGES flops in parallel, so they stay mutually aligned.
- Sample event: a synced qie_ckout 0->1 transition, detected using one further register. The data used is the synced word aligned with the detected edge.
- FSM states: SEEK and LOCKED. Keep internal registers exp_capid (2b) and run (count).
- In SEEK, on a sample:
  - If run==0 or capid!=exp_capid: set run=1.
  - Otherwise: run=run+1.
  - In both cases: exp_capid=capid+1 (mod 4).
  - When run reaches LOCK_COUNT: go to LOCKED, and push that sample.
- In LOCKED, on a sample:
  - capid==exp_capid: push the sample; exp_capid increments.
  - capid mismatch: do not push; capid_err_cnt+1 (saturates at all-ones); go to SEEK with run=1 and exp_capid=capid+1.
- Push: writes {disc, capid, adc} to the FIFO on the cycle after the sample event.
  - If the FIFO is full and no pop occurs that cycle: drop the sample and set overflow=1.
  - If the FIFO is full and a pop occurs in the same cycle: accept the push.
- FIFO: first-word-fall-through.
  - out_valid = not empty.
  - out_* show the head word.
  - Pop happens when out_valid && out_ready.
  - Pointers wrap modulo FIFO_DEPTH; the full/empty distinction uses an extra pointer bit.
- Latency: with the FIFO empty and the block locked, out_valid rises exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples qie_ckout high.
- clr_err: capid_err_cnt=0 and overflow=0 next cycle. If a clear and an error/overflow event coincide, the clear takes priority.
- When out_valid=0, out_adc/out_capid/out_disc hold their last value.
- Reset (including mid-stream):
  - All sync flops, FIFO pointers and the FSM are cleared; the FSM goes to SEEK with run=0.
  - out_valid=0, locked=0, capid_err_cnt=0, overflow=0.
  - out_adc=0, out_capid=0, out_disc=0.
  - Samples in flight are discarded.

Optional Feature:
QIE_DISC_LATCH_EN:
- Defined: out_disc is the OR of synced qie_discout over every clk cycle since the previous sample event, inclusive of the current event cycle. The accumulator clears after each sample event and on reset. This catches narrow discriminator pulses.
- Undefined: out_disc is the synced qie_discout value at the sample event cycle only. No accumulator logic is built.

Test Plan:
- Rotation capIDs 0,1,2,3,0,1 with ADC 0x05..0x0A and out_ready=1 -> locked rises at the 4th sample. Words capid3/0x08, capid0/0x09 and capid1/0x0A are output. capid_err_cnt=0.
- Locked stream 0,1,3 -> sample with capid3 is not output. capid_err_cnt=1, locked=0. Continuing 0,1,2 from there relocks at the sample 3,0,1,2 (4th correct) and output resumes.
- Locked, out_ready=0, 6 samples -> 4 words are held, overflow=1, out_valid=1. Then out_ready=1 -> exactly the first 4 samples drain in order. clr_err -> overflow=0.
- Locked, FIFO empty, single ckout rise -> out_valid asserts exactly SYNC_STAGES+2 = 4 cycles after ckout is first sampled high.
- rst pulsed for one cycle with 2 words buffered -> next cycle out_valid=0, locked=0, counters 0. A fresh rotation needs LOCK_COUNT samples to lock again.
- A 1-cycle qie_discout pulse between two samples -> out_disc=1 on the next word with QIE_DISC_LATCH_EN defined, and out_disc=0 without it.

Source files
------------

// File: rtl/qie_channel_capture.sv
// Per-channel QIE capture: synchronise the QIE outputs, lock onto the capID rotation, buffer samples in an FWFT FIFO.
// Optional build macro QIE_DISC_LATCH_EN: out_disc reports any discriminator activity since the previous sample.
module qie_channel_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOCK_COUNT  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           qie_out,
    input  logic                 qie_ckout,
    input  logic                 qie_discout,
    output logic [5:0]           out_adc,
    output logic [1:0]           out_capid,
    output logic                 out_disc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] capid_err_cnt,
    output logic                 overflow,
    input  logic                 clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(LOCK_COUNT + 1);

    typedef enum logic {ST_SEEK = 1'b0, ST_LOCKED = 1'b1} state_t;

    logic [SYNC_STAGES-1:0]      r_ck_sync;
    logic [SYNC_STAGES-1:0]      r_disc_sync;
    logic [SYNC_STAGES-1:0][7:0] r_word_sync;
    logic                        r_ck_d;
    logic                        w_ck_s;
    logic                        w_disc_s;
    logic [7:0]                  w_word_s;
    logic                        w_edge;
    logic                        w_evt_disc;

    // All three inputs go through identical chains so they stay mutually aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ck_sync   <= '0;
            r_disc_sync <= '0;
            r_word_sync <= '0;
            r_ck_d      <= 1'b0;
        end else begin
            r_ck_sync   <= {r_ck_sync[SYNC_STAGES-2:0], qie_ckout};
            r_disc_sync <= {r_disc_sync[SYNC_STAGES-2:0], qie_discout};
            r_word_sync <= {r_word_sync[SYNC_STAGES-2:0], qie_out};
            r_ck_d      <= w_ck_s;
        end
    end

    assign w_ck_s   = r_ck_sync[SYNC_STAGES-1];
    assign w_disc_s = r_disc_sync[SYNC_STAGES-1];
    assign w_word_s = r_word_sync[SYNC_STAGES-1];
    assign w_edge   = w_ck_s & ~r_ck_d;

`ifdef QIE_DISC_LATCH_EN
    logic r_disc_acc;

    // Accumulate discriminator activity between sample events; the event cycle itself is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disc_acc <= 1'b0;
        end else if (w_edge) begin
            r_disc_acc <= 1'b0;
        end else begin
            r_disc_acc <= r_disc_acc | w_disc_s;
        end
    end

    assign w_evt_disc = r_disc_acc | w_disc_s;
`else
    assign w_evt_disc = w_disc_s;
`endif

    logic       r_evt;
    logic [1:0] r_evt_capid;
    logic [5:0] r_evt_adc;
    logic       r_evt_disc;

    // Capture the synced word aligned with the detected ckout edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt       <= 1'b0;
            r_evt_capid <= 2'd0;
            r_evt_adc   <= 6'd0;
            r_evt_disc  <= 1'b0;
        end else begin
            r_evt <= w_edge;
            if (w_edge) begin
                r_evt_capid <= w_word_s[7:6];
                r_evt_adc   <= w_word_s[5:0];
                r_evt_disc  <= w_evt_disc;
            end else begin
                r_evt_capid <= r_evt_capid;
                r_evt_adc   <= r_evt_adc;
                r_evt_disc  <= r_evt_disc;
            end
        end
    end

    state_t        r_state;
    state_t        w_state_nx;
    logic [1:0]    r_exp;
    logic [1:0]    w_exp_nx;
    logic [RW-1:0] r_run;
    logic [RW-1:0] w_run_nx;
    logic          w_push;
    logic          w_err;

    // capID rotation tracker: SEEK counts consecutive in-order capIDs, LOCKED forwards them.
    always_comb begin
        w_state_nx = r_state;
        w_exp_nx   = r_exp;
        w_run_nx   = r_run;
        w_push     = 1'b0;
        w_err      = 1'b0;
        if (r_evt) begin
            case (r_state)
                ST_SEEK: begin
                    w_exp_nx = r_evt_capid + 2'd1;
                    if ((r_run == RW'(0)) || (r_evt_capid != r_exp)) begin
                        w_run_nx = RW'(1);
                    end else begin
                        w_run_nx = r_run + RW'(1);
                    end
                    if (w_run_nx == RW'(LOCK_COUNT)) begin
                        w_state_nx = ST_LOCKED;
                        w_push     = 1'b1;
                    end else begin
                        w_state_nx = ST_SEEK;
                    end
                end
                ST_LOCKED: begin
                    if (r_evt_capid == r_exp) begin
                        w_push   = 1'b1;
                        w_exp_nx = r_exp + 2'd1;
                    end else begin
                        w_err      = 1'b1;
                        w_state_nx = ST_SEEK;
                        w_run_nx   = RW'(1);
                        w_exp_nx   = r_evt_capid + 2'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_SEEK;
                    w_run_nx   = RW'(0);
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    logic       r_push;
    logic [8:0] r_push_word;

    // FSM state plus the registered push request one cycle behind the event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEEK;
            r_exp       <= 2'd0;
            r_run       <= RW'(0);
            r_push      <= 1'b0;
            r_push_word <= 9'd0;
        end else begin
            r_state     <= w_state_nx;
            r_exp       <= w_exp_nx;
            r_run       <= w_run_nx;
            r_push      <= w_push;
            r_push_word <= w_push ? {r_evt_disc, r_evt_capid, r_evt_adc} : r_push_word;
        end
    end

    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_wr_nx;
    logic [AW:0] w_rd_nx;
    logic        w_full;
    logic        w_pop;
    logic        w_wr_en;
    logic        w_ovf_evt;
    logic [8:0]  w_head_nx;
    logic        r_out_valid;
    logic [8:0]  r_out_word;

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = r_out_valid & out_ready;
    assign w_wr_en   = r_push & (~w_full | w_pop);
    assign w_ovf_evt = r_push & w_full & ~w_pop;
    assign w_wr_nx   = r_wr_ptr + {{AW{1'b0}}, w_wr_en};
    assign w_rd_nx   = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // Head word after this cycle's push/pop; bypass when the new word lands at the head slot.
    always_comb begin
        if (w_wr_en && (r_wr_ptr[AW-1:0] == w_rd_nx[AW-1:0])) begin
            w_head_nx = r_push_word;
        end else begin
            w_head_nx = r_mem[w_rd_nx[AW-1:0]];
        end
    end

    // FIFO storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_push_word;
        end
    end

    // Pointers and registered head; the head holds its last value while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= 9'd0;
        end else begin
            r_wr_ptr    <= w_wr_nx;
            r_rd_ptr    <= w_rd_nx;
            r_out_valid <= (w_wr_nx != w_rd_nx);
            r_out_word  <= (w_wr_nx != w_rd_nx) ? w_head_nx : r_out_word;
        end
    end

    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_overflow;

    // Error bookkeeping; a clear wins over a coincident error or overflow.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            r_err_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_err_cnt  <= (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) ? r_err_cnt + ERR_CNT_W'(1) : r_err_cnt;
            r_overflow <= r_overflow | w_ovf_evt;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_disc      = r_out_word[8];
    assign out_capid     = r_out_word[7:6];
    assign out_adc       = r_out_word[5:0];
    assign locked        = (r_state == ST_LOCKED);
    assign capid_err_cnt = r_err_cnt;
    assign overflow      = r_overflow;

endmodule
